text_color_pipeline: RTL
========================

# text_color_pipeline

Parametrised, pipelined pixel colorizer for the HDMI text controller. For each pixel it takes the font-ROM row and the glyph attributes and produces RGB through a writable palette. It adds inverse video, blink and cursor overlay, and blanking. It sits between the font ROM / VRAM fetch stage and the HDMI encoder, clocked on the pixel clock.

## Interface
- CHANNEL_BITS, 4: bits per colour channel.
- PAL_ENTRIES, 16: palette depth (power of 2); IDX_W = clog2(PAL_ENTRIES).
- FONT_W, 8: glyph width in pixels (power of 2).
- FONT_H, 16: glyph height in pixels (power of 2).
- BLINK_FRAMES, 30: frames per blink half-period (≥1).

- pixel_clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- pal_we  in  1  palette write strobe
- pal_waddr  in  IDX_W  palette write index
- pal_wdata  in  3*CHANNEL_BITS  {R,G,B} write data
- frame_start  in  1  one-cycle pulse per frame (vsync edge)
- cursor_en  in  1  cursor overlay enable
- cursor_col  in  10  cursor character column
- cursor_row  in  10  cursor character row
- in_valid  in  1  pixel qualifier
- in_blank  in  1  1 = outside active video
- drawx, drawy  in  10 each  pixel coordinates
- font_line  in  FONT_W  font row bits, MSB = leftmost pixel
- attr_inv  in  1  inverse video
- attr_blink  in  1  blink attribute
- fg_idx, bg_idx  in  IDX_W each  palette indices
- out_valid  out  1  pixel qualifier, delayed
- red, green, blue  out  CHANNEL_BITS each  pixel colour

## Operation
- Font bit: font_line[FONT_W-1 - (drawx mod FONT_W)].
- The pixel's character cell is col = drawx / FONT_W and row = drawy / FONT_H. cursor_hit = cursor_en && col==cursor_col && row==cursor_row.
- Pixel-on evaluation, in this order:
  - on = bit ^ attr_inv
  - if attr_blink && blink_phase, on = 0
  - if cursor_hit && !blink_phase, on = ~on
- Selected index = on ? fg_idx : bg_idx.
- Blink timer:
  - blink_cnt counts frame_start pulses from 0 to BLINK_FRAMES-1.
  - On the pulse at BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
  - With BLINK_FRAMES=1, blink_phase toggles on every pulse.
- Palette:
  - PAL_ENTRIES × 3*CHANNEL_BITS register array.
  - Synchronous write on pal_we.
  - Reset value: entry 0 = all zeros; entries 1..N-1 = all ones.
- Blank: if the stage-1 blank flag is set, the RGB outputs are 0 regardless of palette contents.
- Outputs are only meaningful when out_valid=1. When in_valid=0 the pipeline still advances, and out_valid follows 2 cycles later.

## Timing
- Reset (async assert, release synchronous to pixel_clk) clears:
  - out_valid=0, red/green/blue=0
  - blink_cnt=0, blink_phase=0
  - all pipeline registers
  - palette to its reset value
- Latency is 2 cycles from in_valid/inputs to out_valid/RGB:
  - Stage 1 registers the selected index, blank and valid.
  - Stage 2 registers the palette lookup (RGB) and valid.
- Throughput is 1 pixel/cycle; there is no backpressure.
- Read-during-write: a stage-2 lookup of the index being written in the same cycle returns the OLD entry. The new value is visible from the next cycle.
- blink_phase changes at the clock edge that samples frame_start. Pixels in stage 1 on that edge use the old phase.
- frame_start and in_valid may coincide; each is handled independently.
- Reset mid-frame: the pipeline flushes and out_valid=0 until 2 cycles after the first post-reset in_valid.

## Structure
- Package text_color_pkg holds:
  - rgb_t (packed struct of three CHANNEL_BITS fields)
  - default parameter constants
  - IDX_W computation
  - a font_bit_sel function
- Sub-module text_palette_ram holds the palette array with its write port, reset initialisation and registered read.
- The top holds the blink timer, the cursor compare, the stage-1 logic, and the blank/valid pipeline.
- Elaboration assertions: FONT_W, FONT_H and PAL_ENTRIES are powers of 2; BLINK_FRAMES ≥ 1.

## Test plan
- **Reset defaults:** with defaults, after reset drive fg_idx=1, bg_idx=0, font_line=8'h80, drawx=0, in_valid=1 → 2 cycles later out_valid=1, RGB=F/F/F; at drawx=1 → RGB=0/0/0.
- **Palette and read-during-write:** write entry 3=12'h4A2 and set fg_idx=3 with font_line=8'hFF → output 4/A/2. Write entry 3=12'h111 on the same cycle as that lookup → the old 4A2 is output, then 111 on the next pixel.
- **Inverse video:** attr_inv=1, font_line=8'h01 at drawx=7 → bg colour; at drawx=0 → fg colour.
- **Blink:** BLINK_FRAMES=2, attr_blink=1, font bit set. Pulse frame_start twice → blink_phase=1 and output = bg. Pulse twice more → output = fg.
- **Cursor:** cursor_en=1, cursor_col=2, cursor_row=1, drawx=16..23, drawy=16..31, font_line=0 → fg colour while blink_phase=0, bg colour while blink_phase=1; drawx=24 → bg.
- **Blank and reset:** in_blank=1 with palette entries nonzero → RGB=0. Assert reset mid-stream → out_valid=0 immediately and the palette returns to its reset values.

Source files
------------

// File: rtl/text_color_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_color_pkg
// Description : Shared types, default parameters and helper functions for the
//               text-mode pixel colorizer.
// Revision    : 1.0 - initial release
// ============================================================================
package text_color_pkg;

    localparam int DEF_CHANNEL_BITS = 4;
    localparam int DEF_PAL_ENTRIES  = 16;
    localparam int DEF_FONT_W       = 8;
    localparam int DEF_FONT_H       = 16;
    localparam int DEF_BLINK_FRAMES = 30;
    localparam int DEF_IDX_W        = $clog2(DEF_PAL_ENTRIES);

    // Pixel coordinate width and the widest font row the bit selector accepts
    localparam int COORD_W       = 10;
    localparam int FONT_LINE_MAX = 64;

    typedef struct packed {
        logic [DEF_CHANNEL_BITS-1:0] r;
        logic [DEF_CHANNEL_BITS-1:0] g;
        logic [DEF_CHANNEL_BITS-1:0] b;
    } rgb_t;

    // Palette index width; a one-entry palette still needs a one-bit index
    function automatic int idx_width(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

    function automatic logic is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Picks the font bit for pixel column x; the leftmost pixel is the MSB
    function automatic logic font_bit_sel(input logic [FONT_LINE_MAX-1:0] line,
                                          input int unsigned               fw,
                                          input logic [COORD_W-1:0]        x);
        int unsigned pos;
        pos = fw - 32'd1 - (32'(x) % fw);
        return line[pos[5:0]];
    endfunction

endpackage
`default_nettype wire

// File: rtl/text_palette_ram.sv
`default_nettype none
// ============================================================================
// Module      : text_palette_ram
// Description : Writable colour palette with registered read. Reads return the
//               entry as it was before a same-cycle write. A blank request
//               forces the registered colour to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module text_palette_ram
    import text_color_pkg::*;
#(
    parameter  int CHANNEL_BITS = DEF_CHANNEL_BITS,
    parameter  int PAL_ENTRIES  = DEF_PAL_ENTRIES,
    localparam int IDX_W        = idx_width(PAL_ENTRIES),
    localparam int RGB_W        = 3 * CHANNEL_BITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [RGB_W-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    input  logic             zero_i,
    output logic [RGB_W-1:0] rdata_o
);

    logic [RGB_W-1:0] pal_q [PAL_ENTRIES];
    logic [RGB_W-1:0] rdata_q;
    logic [RGB_W-1:0] rdata_d;

    // Palette storage: entry 0 resets to black, all others to white
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                pal_q[i] <= (i == 0) ? '0 : '1;
            end
        end else if (we_i) begin
            pal_q[waddr_i] <= wdata_i;
        end
    end

    // Lookup value for the output register, blanked on request
    always_comb begin
        rdata_d = zero_i ? '0 : pal_q[raddr_i];
    end

    // Registered read port
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/text_color_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : text_color_pipeline
// Description : Two-stage text-mode pixel colorizer. Stage 1 resolves the
//               pixel-on state (font bit, inverse, blink, cursor) into a
//               palette index; stage 2 is the palette lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module text_color_pipeline
    import text_color_pkg::*;
#(
    parameter  int CHANNEL_BITS = DEF_CHANNEL_BITS,
    parameter  int PAL_ENTRIES  = DEF_PAL_ENTRIES,
    parameter  int FONT_W       = DEF_FONT_W,
    parameter  int FONT_H       = DEF_FONT_H,
    parameter  int BLINK_FRAMES = DEF_BLINK_FRAMES,
    localparam int IDX_W        = idx_width(PAL_ENTRIES),
    localparam int RGB_W        = 3 * CHANNEL_BITS
) (
    input  logic                    pixel_clk_i,
    input  logic                    reset_i,
    input  logic                    pal_we_i,
    input  logic [IDX_W-1:0]        pal_waddr_i,
    input  logic [RGB_W-1:0]        pal_wdata_i,
    input  logic                    frame_start_i,
    input  logic                    cursor_en_i,
    input  logic [9:0]              cursor_col_i,
    input  logic [9:0]              cursor_row_i,
    input  logic                    in_valid_i,
    input  logic                    in_blank_i,
    input  logic [9:0]              drawx_i,
    input  logic [9:0]              drawy_i,
    input  logic [FONT_W-1:0]       font_line_i,
    input  logic                    attr_inv_i,
    input  logic                    attr_blink_i,
    input  logic [IDX_W-1:0]        fg_idx_i,
    input  logic [IDX_W-1:0]        bg_idx_i,
    output logic                    out_valid_o,
    output logic [CHANNEL_BITS-1:0] red_o,
    output logic [CHANNEL_BITS-1:0] green_o,
    output logic [CHANNEL_BITS-1:0] blue_o
);

    localparam int FW_SH = $clog2(FONT_W);
    localparam int FH_SH = $clog2(FONT_H);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Parameter sanity checks at elaboration time
    if (!is_pow2(FONT_W) || FONT_W > FONT_LINE_MAX) begin : g_chk_font_w
        $error("FONT_W must be a power of 2 no larger than 64");
    end
    if (!is_pow2(FONT_H)) begin : g_chk_font_h
        $error("FONT_H must be a power of 2");
    end
    if (!is_pow2(PAL_ENTRIES)) begin : g_chk_pal
        $error("PAL_ENTRIES must be a power of 2");
    end
    if (BLINK_FRAMES < 1) begin : g_chk_blink
        $error("BLINK_FRAMES must be at least 1");
    end

    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             blank_q;
    logic             valid1_q;
    logic             valid2_q;
    logic             cursor_hit;
    logic             pix_on;
    logic [RGB_W-1:0] rgb;

    // Blink timer: count frames, flip the phase every BLINK_FRAMES frames
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_start_i) begin
            if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Blink timer state
    always_ff @(posedge pixel_clk_i or posedge reset_i) begin
        if (reset_i) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // Cursor cell compare on the character coordinates of this pixel
    assign cursor_hit = cursor_en_i
                     && ((drawx_i >> FW_SH) == cursor_col_i)
                     && ((drawy_i >> FH_SH) == cursor_row_i);

    // Pixel-on resolution; the blink phase seen here is the pre-edge value
    always_comb begin
        pix_on = font_bit_sel(FONT_LINE_MAX'(font_line_i), $unsigned(FONT_W), drawx_i);
        pix_on = pix_on ^ attr_inv_i;
        if (attr_blink_i && blink_phase_q) begin
            pix_on = 1'b0;
        end
        if (cursor_hit && !blink_phase_q) begin
            pix_on = ~pix_on;
        end
        idx_d = pix_on ? fg_idx_i : bg_idx_i;
    end

    // Stage 1 and the stage 2 valid; the pipeline never stalls
    always_ff @(posedge pixel_clk_i or posedge reset_i) begin
        if (reset_i) begin
            idx_q    <= '0;
            blank_q  <= 1'b0;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            blank_q  <= in_blank_i;
            valid1_q <= in_valid_i;
            valid2_q <= valid1_q;
        end
    end

    // Stage 2: palette lookup, forced to black when the pixel is blanked
    text_palette_ram #(
        .CHANNEL_BITS (CHANNEL_BITS),
        .PAL_ENTRIES  (PAL_ENTRIES)
    ) u_palette (
        .clk_i   (pixel_clk_i),
        .rst_i   (reset_i),
        .we_i    (pal_we_i),
        .waddr_i (pal_waddr_i),
        .wdata_i (pal_wdata_i),
        .raddr_i (idx_q),
        .zero_i  (blank_q),
        .rdata_o (rgb)
    );

    assign out_valid_o = valid2_q;
    assign red_o       = rgb[RGB_W-1 -: CHANNEL_BITS];
    assign green_o     = rgb[2*CHANNEL_BITS-1 -: CHANNEL_BITS];
    assign blue_o      = rgb[CHANNEL_BITS-1:0];

endmodule
`default_nettype wire
